// File: rtl/calc_pkg.sv
// Shared calculator types: operand/result word, ALU opcodes and arbiter FSM states.
// Optional feature macro: ALU_ARB_TIMEOUT_EN (adds the S_DRAIN state).
package calc_pkg;

   localparam int unsigned NUM_W = 16;

   // Operand/result word; error is produced by the ALU and carried untouched.
   typedef struct packed {
      logic             error;
      logic [NUM_W-1:0] value;
   } num_t;

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_MUL  = 3'd3,
      OP_DIV  = 3'd4
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
`ifdef ALU_ARB_TIMEOUT_EN
      S_DRAIN = 3'd4,
`endif
      S_RESP  = 3'd3
   } alu_arb_state_t;

   // Index width for an n-entry vector, never below one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or above ptr_i, wrapping.
module rr_arbiter
   import calc_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic               gnt_valid_o
);

   // Scan NUM_REQ positions starting at the pointer; keep the first hit.
   always_comb begin
      logic [IDX_W:0]   pos;
      logic [IDX_W-1:0] idx;
      gnt_o       = '0;
      gnt_idx_o   = '0;
      gnt_valid_o = 1'b0;
      pos         = '0;
      idx         = '0;
      if (en_i) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(NUM_REQ)) begin
               pos = pos - (IDX_W+1)'(NUM_REQ);
            end
            idx = pos[IDX_W-1:0];
            if (!gnt_valid_o && req_i[idx]) begin
               gnt_valid_o = 1'b1;
               gnt_o[idx]  = 1'b1;
               gnt_idx_o   = idx;
            end
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin arbitration and a single
// outstanding operation. Optional feature macro: ALU_ARB_TIMEOUT_EN (S_WAIT watchdog
// followed by S_DRAIN to swallow the late ALU result).
module alu_arbiter
   import calc_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  num_t [NUM_REQ-1:0]  req_left_i,
   input  num_t [NUM_REQ-1:0]  req_right_i,
   input  op_t  [NUM_REQ-1:0]  req_op_i,
   input  logic [NUM_REQ-1:0]  req_valid_i,
   output logic [NUM_REQ-1:0]  req_ready_o,
   output num_t                rsp_result_o,
   output logic [NUM_REQ-1:0]  rsp_valid_o,
   input  logic [NUM_REQ-1:0]  rsp_ready_i,
   output num_t                alu_left_o,
   output num_t                alu_right_o,
   output op_t                 alu_op_o,
   output logic                alu_in_valid_o,
   input  logic                alu_in_ready_i,
   input  num_t                alu_result_i,
   input  logic                alu_out_valid_i,
   output logic                alu_out_ready_o
);

   localparam int unsigned IDX_W = idx_width(NUM_REQ);

   if ((NUM_REQ < 2) || (NUM_REQ > 8) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
      $error("alu_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
   end

   alu_arb_state_t   state_q;
   logic [IDX_W-1:0] rr_ptr_q;
   logic [IDX_W-1:0] owner_q;
   num_t             left_q;
   num_t             right_q;
   op_t              op_q;
   num_t             result_q;

`ifdef ALU_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] tmo_cnt_q;
   logic             timed_out_q;
`endif

   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_valid;

   // Grants are only offered in S_IDLE and never while reset is asserted.
   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req_i       (req_valid_i),
      .ptr_i       (rr_ptr_q),
      .en_i        (rst_ni && (state_q == S_IDLE)),
      .gnt_o       (gnt),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_valid)
   );

   // FSM and command/result registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         left_q      <= '0;
         right_q     <= '0;
         op_q        <= OP_NONE;
         result_q    <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
         tmo_cnt_q   <= '0;
         timed_out_q <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (gnt_valid) begin
                  owner_q <= gnt_idx;
                  left_q  <= req_left_i[gnt_idx];
                  right_q <= req_right_i[gnt_idx];
                  op_q    <= req_op_i[gnt_idx];
                  if (32'(gnt_idx) == NUM_REQ - 1) begin
                     rr_ptr_q <= '0;
                  end else begin
                     rr_ptr_q <= gnt_idx + 1'b1;
                  end
                  // OP_NONE is a pass-through of the left operand and skips the ALU.
                  if (req_op_i[gnt_idx] == OP_NONE) begin
                     result_q <= req_left_i[gnt_idx];
                     state_q  <= S_RESP;
                  end else begin
                     state_q  <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (alu_in_ready_i) begin
                  state_q   <= S_WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
                  tmo_cnt_q <= '0;
`endif
               end
            end
            S_WAIT: begin
               if (alu_out_valid_i) begin
                  result_q <= alu_result_i;
                  state_q  <= S_RESP;
`ifdef ALU_ARB_TIMEOUT_EN
               end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  result_q    <= '{error: 1'b1, value: '0};
                  timed_out_q <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
               end
            end
            S_RESP: begin
               if (rsp_ready_i[owner_q]) begin
`ifdef ALU_ARB_TIMEOUT_EN
                  // After a timeout the ALU still owes a result; swallow it first.
                  state_q     <= timed_out_q ? S_DRAIN : S_IDLE;
                  timed_out_q <= 1'b0;
`else
                  state_q     <= S_IDLE;
`endif
               end
            end
`ifdef ALU_ARB_TIMEOUT_EN
            S_DRAIN: begin
               if (alu_out_valid_i) begin
                  state_q <= S_IDLE;
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Output decode from the state register; the command is held stable while the ALU owns it.
   always_comb begin
      logic cmd_active;
      cmd_active      = (state_q == S_ISSUE) || (state_q == S_WAIT);
      alu_out_ready_o = (state_q == S_WAIT);
`ifdef ALU_ARB_TIMEOUT_EN
      cmd_active      = cmd_active || (state_q == S_DRAIN);
      alu_out_ready_o = alu_out_ready_o || (state_q == S_DRAIN);
`endif
      alu_in_valid_o = (state_q == S_ISSUE);
      alu_left_o     = cmd_active ? left_q  : '0;
      alu_right_o    = cmd_active ? right_q : '0;
      alu_op_o       = cmd_active ? op_q    : OP_NONE;
      req_ready_o    = gnt;
      rsp_valid_o    = '0;
      rsp_result_o   = '0;
      if (state_q == S_RESP) begin
         rsp_valid_o[owner_q] = 1'b1;
         rsp_result_o         = result_q;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with two requesters, a behavioural ALU and a
// response scoreboard. Covers ALU_ARB_TIMEOUT_EN when that macro is defined.
module tb_alu_arbiter;
   import calc_pkg::*;

   localparam int unsigned NR = 2;

   typedef struct {
      int   owner;
      num_t res;
   } exp_t;

   logic              clk;
   logic              rst_ni;
   num_t [NR-1:0]     req_left;
   num_t [NR-1:0]     req_right;
   op_t  [NR-1:0]     req_op;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   num_t              rsp_result;
   logic [NR-1:0]     rsp_valid;
   logic [NR-1:0]     rsp_ready;
   num_t              alu_left;
   num_t              alu_right;
   op_t               alu_op;
   logic              alu_in_valid;
   logic              alu_in_ready;
   num_t              alu_result;
   logic              alu_out_valid;
   logic              alu_out_ready;
   logic              alu_ov_en;

   num_t [NR-1:0]     req_exp;
   exp_t              sb[$];
   int                grants[$];
   int                n_checks;
   int                n_err;
   int                n_rsp;
   int                inval_cnt;

   alu_arbiter #(
      .NUM_REQ        (NR),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .req_left_i      (req_left),
      .req_right_i     (req_right),
      .req_op_i        (req_op),
      .req_valid_i     (req_valid),
      .req_ready_o     (req_ready),
      .rsp_result_o    (rsp_result),
      .rsp_valid_o     (rsp_valid),
      .rsp_ready_i     (rsp_ready),
      .alu_left_o      (alu_left),
      .alu_right_o     (alu_right),
      .alu_op_o        (alu_op),
      .alu_in_valid_o  (alu_in_valid),
      .alu_in_ready_i  (alu_in_ready),
      .alu_result_i    (alu_result),
      .alu_out_valid_i (alu_out_valid),
      .alu_out_ready_o (alu_out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural combinational ALU; out_valid is gated by the bench.
   always_comb begin
      alu_result = '0;
      case (alu_op)
         OP_ADD: alu_result.value = alu_left.value + alu_right.value;
         OP_SUB: alu_result.value = alu_left.value - alu_right.value;
         OP_MUL: alu_result.value = alu_left.value * alu_right.value;
         OP_DIV: begin
            if (alu_right.value == '0) alu_result.error = 1'b1;
            else alu_result.value = alu_left.value / alu_right.value;
         end
         default: alu_result = '0;
      endcase
   end
   assign alu_out_valid = alu_ov_en;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic num_t mk(input int v, input bit err);
      num_t n;
      n.error = err;
      n.value = 16'(v);
      return n;
   endfunction

   task automatic set_req(input int i, input op_t op, input int l, input int r, input num_t e);
      req_op[1'(i)]    = op;
      req_left[1'(i)]  = mk(l, 1'b0);
      req_right[1'(i)] = mk(r, 1'b0);
      req_exp[1'(i)]   = e;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input int idx);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (rsp_valid[1'(idx)]) begin
            ok = 1'b1;
            break;
         end
      end
      check("wait_rsp", 32'(ok), 32'd1);
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      sb.delete();
      cyc();
      cyc();
      rst_ni = 1'b1;
      cyc();
   endtask

   // Scoreboard: push on request handshake, pop and compare on response handshake.
   always @(negedge clk) begin
      if (rst_ni) begin
         for (int i = 0; i < NR; i++) begin
            if (req_valid[1'(i)] && req_ready[1'(i)]) begin
               check("one_outstanding", 32'(sb.size()), 32'd0);
               sb.push_back('{owner: i, res: req_exp[1'(i)]});
               grants.push_back(i);
            end
         end
         if (rsp_valid != '0) begin
            check("rsp_onehot", 32'($onehot0(rsp_valid)), 32'd1);
            for (int i = 0; i < NR; i++) begin
               if (rsp_valid[1'(i)] && rsp_ready[1'(i)]) begin
                  if (sb.size() == 0) begin
                     check("rsp_unexpected", 32'd1, 32'd0);
                  end else begin
                     exp_t e;
                     e = sb.pop_front();
                     check("rsp_owner", 32'(i), 32'(e.owner));
                     check("rsp_result", 32'(rsp_result), 32'(e.res));
                  end
                  n_rsp++;
               end
            end
         end
         if (alu_in_valid) inval_cnt++;
      end
   end

   initial begin
      int rsp_snap;
      int wait_cnt;
      n_checks = 0; n_err = 0; n_rsp = 0; inval_cnt = 0;
      rst_ni = 1'b0;
      req_valid = '0; rsp_ready = '1; alu_in_ready = 1'b1; alu_ov_en = 1'b1;
      req_left = '0; req_right = '0; req_exp = '0;
      req_op = {OP_NONE, OP_NONE};

      // Reset state
      cyc(); cyc();
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_in_valid", 32'(alu_in_valid), 32'd0);
      check("rst_out_ready", 32'(alu_out_ready), 32'd0);
      check("rst_alu_left", 32'(alu_left), 32'd0);
      check("rst_rsp_result", 32'(rsp_result), 32'd0);
      cyc();
      rst_ni = 1'b1;
      cyc();

      // 1: single ADD, minimum latency
      inval_cnt = 0;
      set_req(0, OP_ADD, 3, 4, mk(7, 1'b0));
      req_valid = 2'b01;
      @(negedge clk);
      check("t1_ready_T", 32'(req_ready), 32'd1);
      cyc();
      req_valid = '0;
      @(negedge clk);
      check("t1_in_valid_T1", 32'(alu_in_valid), 32'd1);
      check("t1_alu_left", 32'(alu_left.value), 32'd3);
      check("t1_alu_op", 32'(alu_op), 32'(OP_ADD));
      cyc();
      @(negedge clk);
      check("t1_in_valid_T2", 32'(alu_in_valid), 32'd0);
      check("t1_out_ready_T2", 32'(alu_out_ready), 32'd1);
      cyc();
      @(negedge clk);
      check("t1_rsp_valid_T3", 32'(rsp_valid), 32'd1);
      check("t1_rsp_result", 32'(rsp_result.value), 32'd7);
      cyc();
      @(negedge clk);
      check("t1_rsp_done", 32'(rsp_valid), 32'd0);
      check("t1_in_valid_cnt", 32'(inval_cnt), 32'd1);
      cyc();

      // 2: both requesters continuously valid from reset
      do_reset();
      grants.delete();
      n_rsp = 0;
      set_req(0, OP_SUB, 10, 2, mk(8, 1'b0));
      set_req(1, OP_SUB, 10, 2, mk(8, 1'b0));
      req_valid = 2'b11;
      for (int n = 0; n < 60; n++) begin
         cyc();
         if (n_rsp >= 4) break;
      end
      req_valid = '0;
      check("t2_rsp_count", 32'(n_rsp), 32'd4);
      check("t2_grant_count", 32'(grants.size()), 32'd4);
      if (grants.size() >= 4) begin
         check("t2_grant0", 32'(grants[0]), 32'd0);
         check("t2_grant1", 32'(grants[1]), 32'd1);
         check("t2_grant2", 32'(grants[2]), 32'd0);
         check("t2_grant3", 32'(grants[3]), 32'd1);
      end

      // 3: response back-pressure on requester 1
      set_req(1, OP_ADD, 5, 6, mk(11, 1'b0));
      rsp_ready = 2'b01;
      req_valid = 2'b10;
      cyc();
      req_valid = '0;
      wait_rsp(1);
      cyc();
      set_req(0, OP_ADD, 1, 1, mk(2, 1'b0));
      req_valid = 2'b01;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         check("t3_rsp_held", 32'(rsp_valid), 32'd2);
         check("t3_result_held", 32'(rsp_result.value), 32'd11);
         check("t3_no_grant", 32'(req_ready), 32'd0);
         cyc();
      end
      rsp_ready = '1;
      cyc();
      @(negedge clk);
      check("t3_req0_grant", 32'(req_ready), 32'd1);
      cyc();
      req_valid = '0;
      wait_rsp(0);
      cyc();

      // 4: ALU input back-pressure
      alu_in_ready = 1'b0;
      set_req(0, OP_ADD, 20, 22, mk(42, 1'b0));
      req_valid = 2'b01;
      @(negedge clk);
      check("t4_ready", 32'(req_ready), 32'd1);
      cyc();
      req_valid = '0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         check("t4_in_valid_held", 32'(alu_in_valid), 32'd1);
         check("t4_left_stable", 32'(alu_left.value), 32'd20);
         check("t4_right_stable", 32'(alu_right.value), 32'd22);
         check("t4_op_stable", 32'(alu_op), 32'(OP_ADD));
         cyc();
      end
      alu_in_ready = 1'b1;
      @(negedge clk);
      check("t4_in_valid_rdy", 32'(alu_in_valid), 32'd1);
      cyc();
      @(negedge clk);
      check("t4_wait_in_valid", 32'(alu_in_valid), 32'd0);
      check("t4_wait_out_ready", 32'(alu_out_ready), 32'd1);
      cyc();
      wait_rsp(0);
      cyc();

      // 5: OP_NONE bypass, error pass-through, reset mid-S_WAIT
      inval_cnt = 0;
      set_req(1, OP_NONE, 9, 3, mk(9, 1'b0));
      req_valid = 2'b10;
      @(negedge clk);
      check("t5_ready", 32'(req_ready), 32'd2);
      cyc();
      req_valid = '0;
      @(negedge clk);
      check("t5_rsp_T1", 32'(rsp_valid), 32'd2);
      check("t5_result", 32'(rsp_result), 32'(mk(9, 1'b0)));
      check("t5_no_alu", 32'(inval_cnt), 32'd0);
      cyc();
      set_req(1, OP_DIV, 7, 0, mk(0, 1'b1));
      req_valid = 2'b10;
      cyc();
      req_valid = '0;
      wait_rsp(1);
      cyc();
      alu_ov_en = 1'b0;
      set_req(0, OP_ADD, 1, 2, mk(3, 1'b0));
      req_valid = 2'b01;
      cyc();
      req_valid = '0;
      cyc();
      @(negedge clk);
      check("t5_in_wait", 32'(alu_out_ready), 32'd1);
      #2;
      rst_ni = 1'b0;
      sb.delete();
      #1;
      check("t5_rst_out_ready", 32'(alu_out_ready), 32'd0);
      check("t5_rst_in_valid", 32'(alu_in_valid), 32'd0);
      check("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t5_rst_alu_left", 32'(alu_left), 32'd0);
      check("t5_rst_alu_op", 32'(alu_op), 32'(OP_NONE));
      cyc();
      cyc();
      rst_ni = 1'b1;
      alu_ov_en = 1'b1;
      rsp_snap = n_rsp;
      repeat (5) cyc();
      @(negedge clk);
      check("t5_no_rsp_count", 32'(n_rsp), 32'(rsp_snap));
      check("t5_no_rsp_valid", 32'(rsp_valid), 32'd0);
      cyc();

      // 6: ALU result withheld
`ifdef ALU_ARB_TIMEOUT_EN
      alu_ov_en = 1'b0;
      set_req(0, OP_ADD, 4, 4, mk(0, 1'b1));
      req_valid = 2'b01;
      cyc();
      req_valid = '0;
      wait_cnt = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (rsp_valid[0]) break;
         if (alu_out_ready) wait_cnt++;
      end
      check("t6_wait_cycles", 32'(wait_cnt), 32'd8);
      check("t6_err_rsp", 32'(rsp_valid), 32'd1);
      cyc();
      alu_ov_en = 1'b1;
      set_req(1, OP_ADD, 2, 3, mk(5, 1'b0));
      req_valid = 2'b10;
      @(negedge clk);
      check("t6_drain_out_ready", 32'(alu_out_ready), 32'd1);
      check("t6_drain_no_grant", 32'(req_ready), 32'd0);
      check("t6_drain_cmd_held", 32'(alu_left.value), 32'd4);
      cyc();
      @(negedge clk);
      check("t6_after_drain_grant", 32'(req_ready), 32'd2);
      cyc();
      req_valid = '0;
      wait_rsp(1);
      cyc();
`else
      wait_cnt = 0;
      alu_ov_en = 1'b0;
      set_req(0, OP_ADD, 4, 4, mk(8, 1'b0));
      req_valid = 2'b01;
      cyc();
      req_valid = '0;
      repeat (100) cyc();
      @(negedge clk);
      check("t6_still_wait", 32'(alu_out_ready), 32'd1);
      check("t6_no_rsp", 32'(rsp_valid), 32'(wait_cnt));
      cyc();
      alu_ov_en = 1'b1;
      wait_rsp(0);
      cyc();
`endif

      cyc();
      @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
